// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection
//
// Registers decoded control and operands from ID for the EX stage of the
// reduced RV32 pipeline (LW, SW, BEQ, ADD, SUB, AND, OR, XOR, SLT).
// It also detects load-use hazards, inserts bubbles on stall or branch
// flush, and counts the bubbles inserted for hazards with a saturating counter.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_*                  decoded instruction fields from the ID stage
//   flush                 taken branch, kill the instruction in ID
//   ex_*                  registered copies of id_* for the EX stage
//   stall                 hold PC and IF/ID this cycle (combinational)
//   stall_count           number of hazard bubbles, saturates at all-ones
module id_ex_stage_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_uses_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [1:0]         id_alu_op,
    input  logic [2:0]         id_funct3,
    input  logic               id_funct7_5,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_branch,
    input  logic               flush,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_pc,
    output logic [1:0]         ex_alu_op,
    output logic [2:0]         ex_funct3,
    output logic               ex_funct7_5,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_count
);

    logic src_match;
    logic bubble;

    // rs2 only counts as a source when the instruction actually reads it,
    // so immediate-form consumers never stall on a stale rs2 field.
    assign src_match = (id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd));

    // The bubble this inserts clears ex_valid, so the hazard term drops on
    // the following cycle and the stall lasts exactly one cycle.
    assign stall = !reset && id_valid && ex_valid && ex_mem_read &&
                   (ex_rd != '0) && src_match && !flush;

    assign bubble = flush || stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_alu_op     <= 2'b00;
            ex_funct3     <= 3'b000;
            ex_funct7_5   <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (bubble) begin
            ex_valid      <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_alu_op     <= 2'b00;
            ex_funct3     <= 3'b000;
            ex_funct7_5   <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else begin
            // Data always follows ID; control is gated by id_valid so an
            // empty ID slot becomes an architectural no-op in EX.
            ex_valid      <= id_valid;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_pc         <= id_pc;
            ex_alu_op     <= id_valid ? id_alu_op : 2'b00;
            ex_funct3     <= id_funct3;
            ex_funct7_5   <= id_funct7_5;
            ex_alu_src    <= id_valid && id_alu_src;
            ex_mem_read   <= id_valid && id_mem_read;
            ex_mem_write  <= id_valid && id_mem_write;
            ex_reg_write  <= id_valid && id_reg_write;
            ex_mem_to_reg <= id_valid && id_mem_to_reg;
            ex_branch     <= id_valid && id_branch;
        end
    end

    // Counts hazard bubbles only; flush bubbles are excluded because stall
    // is already masked by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_5, id_alu_src, id_mem_read, id_mem_write;
    logic        id_reg_write, id_mem_to_reg, id_branch, flush;

    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [1:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5, ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch, stall;
    logic [15:0] stall_count;

    logic        s_valid;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
    logic [1:0]  s_alu_op;
    logic [2:0]  s_funct3;
    logic        s_funct7_5, s_alu_src, s_mem_read, s_mem_write;
    logic        s_reg_write, s_mem_to_reg, s_branch, s_stall;
    logic [3:0]  s_stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .flush(flush),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .flush(flush),
        .ex_valid(s_valid), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_pc(s_pc),
        .ex_alu_op(s_alu_op), .ex_funct3(s_funct3), .ex_funct7_5(s_funct7_5),
        .ex_alu_src(s_alu_src), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
        .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg), .ex_branch(s_branch),
        .stall(s_stall), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs2 = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_alu_op = 2'b00; id_funct3 = 3'b000; id_funct7_5 = 0;
        id_alu_src = 0; id_mem_read = 0; id_mem_write = 0;
        id_reg_write = 0; id_mem_to_reg = 0; id_branch = 0; flush = 0;
    endtask

    // LW rd, 4(rs1)
    task automatic drive_lw(input logic [4:0] rd);
        clear_id();
        id_valid = 1; id_rs1 = 5'd1; id_rd = rd; id_imm = 32'd4; id_pc = 32'h100;
        id_funct3 = 3'b010; id_alu_src = 1; id_mem_read = 1;
        id_reg_write = 1; id_mem_to_reg = 1;
    endtask

    // ADD rd, rs1, rs2
    task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        clear_id();
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs2 = 1;
        id_rs1_data = 32'd10; id_rs2_data = 32'd20; id_pc = 32'h104;
        id_alu_op = 2'b10; id_reg_write = 1;
    endtask

    initial begin
        clear_id();
        reset = 1;
        tick();
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_alu_op", ex_alu_op, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall", stall, 0);
        reset = 0;

        // ADD x3,x1,x2 passes straight through
        drive_add(5'd3, 5'd1, 5'd2);
        #1 chk("add_no_stall", stall, 0);
        tick();
        chk("add_alu_op", ex_alu_op, 2'b10);
        chk("add_funct3", ex_funct3, 3'b000);
        chk("add_funct7_5", ex_funct7_5, 0);
        chk("add_rd", ex_rd, 3);
        chk("add_reg_write", ex_reg_write, 1);
        chk("add_valid", ex_valid, 1);
        chk("add_rs1_data", ex_rs1_data, 10);
        chk("add_rs2_data", ex_rs2_data, 20);

        // asynchronous reset with the ADD sitting in EX
        reset = 1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_reg_write", ex_reg_write, 0);
        chk("arst_alu_op", ex_alu_op, 0);
        chk("arst_rs1_data", ex_rs1_data, 0);
        chk("arst_stall", stall, 0);
        reset = 0;
        clear_id();
        tick();

        // load-use: LW x5 then ADD x6,x5,x7
        drive_lw(5'd5);
        tick();
        chk("lw_mem_read", ex_mem_read, 1);
        chk("lw_rd", ex_rd, 5);
        drive_add(5'd6, 5'd5, 5'd7);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_count", stall_count, 1);
        chk("lu_stall_drop", stall, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_count_hold", stall_count, 1);

        // LW x0 followed by a consumer of x0
        drive_lw(5'd0);
        tick();
        drive_add(5'd6, 5'd0, 5'd0);
        #1 chk("x0_no_stall", stall, 0);

        // LW x5 then immediate-form consumer with stale rs2=5
        drive_lw(5'd5);
        tick();
        drive_add(5'd6, 5'd1, 5'd5);
        id_uses_rs2 = 0;
        #1 chk("rs2_unused_no_stall", stall, 0);
        id_uses_rs2 = 1;
        #1 chk("rs2_used_stall", stall, 1);
        id_uses_rs2 = 0;
        tick();
        chk("rs2_unused_loaded", ex_valid, 1);
        chk("rs2_unused_count", stall_count, 1);

        // flush coinciding with a load-use condition
        drive_lw(5'd5);
        tick();
        drive_add(5'd6, 5'd5, 5'd7);
        flush = 1;
        #1 chk("flush_stall", stall, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_rd", ex_rd, 0);
        chk("flush_reg_write", ex_reg_write, 0);
        chk("flush_count", stall_count, 1);
        flush = 0;

        // empty ID slot: control forced off, data still loaded
        clear_id();
        id_rd = 5'd9; id_reg_write = 1; id_mem_read = 1; id_alu_op = 2'b10;
        id_rs1_data = 32'hdead;
        tick();
        chk("idle_valid", ex_valid, 0);
        chk("idle_reg_write", ex_reg_write, 0);
        chk("idle_mem_read", ex_mem_read, 0);
        chk("idle_alu_op", ex_alu_op, 0);
        chk("idle_rd", ex_rd, 9);
        chk("idle_rs1_data", ex_rs1_data, 32'hdead);

        // 14 more hazards brings both counters to 15
        for (int i = 0; i < 14; i++) begin
            drive_lw(5'd5);
            tick();
            drive_add(5'd6, 5'd5, 5'd7);
            tick();
        end
        chk("sat_main_15", stall_count, 15);
        chk("sat_small_15", s_stall_count, 15);
        for (int i = 0; i < 4; i++) begin
            drive_lw(5'd5);
            tick();
            drive_add(5'd6, 5'd5, 5'd7);
            #1 chk("sat_stall_still", s_stall, 1);
            tick();
        end
        chk("sat_main_19", stall_count, 19);
        chk("sat_small_hold", s_stall_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
